// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_pkg
//  Brief    : Shared types and constants for the data-side bridge responder.
//  Revision : 1.0 - initial release
// ============================================================================
package bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DEV_DM = 2'd0,
      DEV_T0 = 2'd1,
      DEV_T1 = 2'd2
   } dev_idx_t;

   localparam int          NDEV          = 3;
   localparam logic [31:0] TMR_WIN_BYTES = 32'd12;

   localparam logic [31:0] DEF_DM_LIMIT  = 32'h0000_2FFF;
   localparam logic [31:0] DEF_T0_BASE   = 32'h0000_7F00;
   localparam logic [31:0] DEF_T1_BASE   = 32'h0000_7F10;
   localparam int          DEF_TIMEOUT   = 16;

endpackage
`default_nettype wire

// File: rtl/bridge_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_responder_if
//  Brief    : CPU request/response and device handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface bridge_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [2:0]  dev_sel;
   logic        dev_we;
   logic [31:0] dev_addr;
   logic [3:0]  dev_be;
   logic [31:0] dev_wdata;
   logic [2:0]  dev_ack;
   logic [95:0] dev_rdata;

   // Responder side
   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, dev_ack, dev_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             dev_sel, dev_we, dev_addr, dev_be, dev_wdata
   );

   // CPU/device side
   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, dev_ack, dev_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             dev_sel, dev_we, dev_addr, dev_be, dev_wdata
   );

endinterface
`default_nettype wire

// File: rtl/bridge_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_addr_decode
//  Brief    : Address to one-hot device hit plus offset within the window.
//  Revision : 1.0 - initial release
// ============================================================================
module bridge_addr_decode
   import bridge_pkg::*;
#(
   parameter logic [31:0] DM_LIMIT = DEF_DM_LIMIT,
   parameter logic [31:0] T0_BASE  = DEF_T0_BASE,
   parameter logic [31:0] T1_BASE  = DEF_T1_BASE
) (
   input  logic [31:0] addr,
   output logic [2:0]  hit,
   output logic [31:0] offset
);

   logic [31:0] w_aligned;

   // Byte lanes come from be, so the low address bits never affect the decode
   assign w_aligned = {addr[31:2], 2'b00};

   // Priority range decode: DM first, then TIMER0, then TIMER1
   always_comb begin
      hit    = '0;
      offset = addr;
      if (w_aligned <= DM_LIMIT) begin
         hit[DEV_DM] = 1'b1;
      end else if ((w_aligned >= T0_BASE) &&
                   (w_aligned <= T0_BASE + TMR_WIN_BYTES - 32'd1)) begin
         hit[DEV_T0] = 1'b1;
         offset      = addr - T0_BASE;
      end else if ((w_aligned >= T1_BASE) &&
                   (w_aligned <= T1_BASE + TMR_WIN_BYTES - 32'd1)) begin
         hit[DEV_T1] = 1'b1;
         offset      = addr - T1_BASE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bridge_responder.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_responder
//  Brief    : Single-outstanding load/store responder with device wait
//             states, timeout and registered interrupt vector.
//  Revision : 1.0 - initial release
// ============================================================================
module bridge_responder
   import bridge_pkg::*;
#(
   parameter logic [31:0] DM_LIMIT = DEF_DM_LIMIT,
   parameter logic [31:0] T0_BASE  = DEF_T0_BASE,
   parameter logic [31:0] T1_BASE  = DEF_T1_BASE,
   parameter int          TIMEOUT  = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   bridge_responder_if.slave  bus,
   input  logic [1:0]         dev_irq,
   output logic [5:0]         hwint
);

   localparam int            CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [3:0]    r_be;
   logic [31:0]   r_wdata;
   logic [2:0]    r_sel;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [5:0]    r_hwint;

   logic [2:0]    w_hit;
   logic [31:0]   w_offset;
   logic          w_go;
   logic          w_ack;
   logic          w_last;
   logic [31:0]   w_sel_rdata;

   bridge_addr_decode #(
      .DM_LIMIT (DM_LIMIT),
      .T0_BASE  (T0_BASE),
      .T1_BASE  (T1_BASE)
   ) u_decode (
      .addr   (bus.req_addr),
      .hit    (w_hit),
      .offset (w_offset)
   );

   // A request reaches a device only when it decodes and enables a lane
   assign w_go   = (|w_hit) && (|bus.req_be);
   assign w_ack  = |(bus.dev_ack & r_sel);
   assign w_last = (r_cnt == C_CNT_LAST);

   // Read data of the selected device (r_sel is one-hot or zero)
   always_comb begin
      w_sel_rdata = '0;
      for (int i = 0; i < NDEV; i++) begin
         if (r_sel[i]) begin
            w_sel_rdata = w_sel_rdata | bus.dev_rdata[32*i +: 32];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_nxt    = r_state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      bus.resp_err   = 1'b0;
      bus.dev_sel    = '0;
      case (r_state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               w_state_nxt = w_go ? WAIT : RESP;
            end
         end
         WAIT: begin
            bus.dev_sel = r_sel;
            if (w_ack || w_last) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = r_rdata;
            bus.resp_err   = r_err;
            w_state_nxt    = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request latch, wait counter and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_we    <= bus.req_we;
                  r_addr  <= w_offset;
                  r_be    <= bus.req_be;
                  r_wdata <= bus.req_wdata;
                  r_sel   <= w_go ? w_hit : 3'b000;
                  r_cnt   <= '0;
                  r_rdata <= '0;
                  r_err   <= !w_go;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_ack) begin
                  r_rdata <= r_we ? 32'd0 : w_sel_rdata;
                  r_err   <= 1'b0;
               end else if (w_last) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Interrupt lines are registered regardless of the transaction state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hwint <= '0;
      end else begin
         r_hwint <= {4'b0000, dev_irq};
      end
   end

   assign bus.dev_we    = r_we;
   assign bus.dev_addr  = r_addr;
   assign bus.dev_be    = r_be;
   assign bus.dev_wdata = r_wdata;
   assign hwint         = r_hwint;

endmodule
`default_nettype wire

// File: tb/tb_bridge_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bridge_responder
//  Brief    : Self-checking bench for bridge_responder with a transaction
//             level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bridge_responder;

   localparam logic [31:0] DM_LIMIT = 32'h0000_2FFF;
   localparam logic [31:0] T0_BASE  = 32'h0000_7F00;
   localparam logic [31:0] T1_BASE  = 32'h0000_7F10;
   localparam int          TIMEOUT  = 16;
   localparam int          NEVER    = 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dev_irq = 2'b00;
   logic [5:0] hwint;
   logic [1:0] last_irq = 2'b00;

   int total = 0;
   int bad   = 0;

   bridge_responder_if bif ();

   bridge_responder #(
      .DM_LIMIT (DM_LIMIT),
      .T0_BASE  (T0_BASE),
      .T1_BASE  (T1_BASE),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bif.slave),
      .dev_irq (dev_irq),
      .hwint   (hwint)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Which device a request should reach; -1 means an error response
   function automatic int model_dev(input logic [31:0] addr, input logic [3:0] be);
      logic [31:0] a;
      a = addr & 32'hFFFF_FFFC;
      if (be == 4'h0)                         return -1;
      if (a <= DM_LIMIT)                      return 0;
      if (a >= T0_BASE && a - T0_BASE < 12)   return 1;
      if (a >= T1_BASE && a - T1_BASE < 12)   return 2;
      return -1;
   endfunction

   function automatic logic [31:0] model_base(input int dev);
      if (dev == 1) return T0_BASE;
      if (dev == 2) return T1_BASE;
      return 32'd0;
   endfunction

   // Interrupt vector follows the previous cycle's irq lines
   task automatic irq_step();
      logic [1:0] nv;
      check("hwint", hwint, {4'b0000, last_irq});
      nv       = 2'($urandom_range(0, 3));
      dev_irq  = nv;
      last_irq = nv;
   endtask

   // One full transaction; d = number of extra wait cycles before the ack
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int d, input logic [95:0] rd);
      int          dev;
      int          exp_n;
      bit          tmo;
      logic [2:0]  exp_sel;
      logic [31:0] exp_rdata;
      logic [2:0]  acks;
      dev     = model_dev(addr, be);
      tmo     = (dev >= 0) && (d >= TIMEOUT);
      exp_sel = (dev < 0) ? 3'b000 : 3'(1 << dev);
      exp_n   = (dev < 0) ? 1 : ((d < TIMEOUT) ? d + 2 : TIMEOUT + 1);
      exp_rdata = (dev < 0 || tmo || we) ? 32'd0 : rd[32*dev +: 32];

      @(negedge clk);
      check("ready_idle", bif.req_ready, 1'b1);
      irq_step();
      bif.req_valid = 1'b1;
      bif.req_we    = we;
      bif.req_addr  = addr;
      bif.req_be    = be;
      bif.req_wdata = wdata;
      bif.dev_rdata = rd;
      bif.dev_ack   = 3'b000;

      for (int n = 1; n <= exp_n + 1; n++) begin
         @(negedge clk);
         bif.req_valid = 1'b0;
         irq_step();
         if (n < exp_n) begin
            check("sel_wait", bif.dev_sel, exp_sel);
            check("rv_wait", bif.resp_valid, 1'b0);
            check("ready_wait", bif.req_ready, 1'b0);
            check("rdata_quiet", bif.resp_rdata, 32'd0);
            if (n == 1) begin
               check("dev_addr", bif.dev_addr, addr - model_base(dev));
               check("dev_we", bif.dev_we, we);
               check("dev_be", bif.dev_be, be);
               check("dev_wdata", bif.dev_wdata, wdata);
            end
            acks = 3'($urandom_range(0, 7)) & ~exp_sel;
            if (n == d + 1) acks = acks | exp_sel;
            bif.dev_ack = acks;
         end else if (n == exp_n) begin
            check("rv_resp", bif.resp_valid, 1'b1);
            check("rdata", bif.resp_rdata, exp_rdata);
            check("err", bif.resp_err, (dev < 0) || tmo);
            check("sel_resp", bif.dev_sel, 3'b000);
            check("ready_resp", bif.req_ready, 1'b0);
            bif.dev_ack   = 3'b000;
            bif.req_valid = 1'b1;
            bif.req_we    = 1'($urandom_range(0, 1));
            bif.req_addr  = 32'h10;
            bif.req_be    = 4'hF;
         end else begin
            check("rv_after", bif.resp_valid, 1'b0);
            check("ready_after", bif.req_ready, 1'b1);
            check("sel_after", bif.dev_sel, 3'b000);
            check("err_after", bif.resp_err, 1'b0);
         end
      end
   endtask

   // Abort a TIMER1 transaction with reset while it is waiting
   task automatic reset_in_wait();
      int seen;
      @(negedge clk);
      irq_step();
      bif.req_valid = 1'b1;
      bif.req_we    = 1'b0;
      bif.req_addr  = T1_BASE + 32'd4;
      bif.req_be    = 4'hF;
      bif.dev_ack   = 3'b000;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         bif.req_valid = 1'b0;
         irq_step();
         check("rst_sel_wait", bif.dev_sel, 3'b100);
      end
      rst     = 1'b1;
      dev_irq = 2'b11;
      @(negedge clk);
      check("rst_ready", bif.req_ready, 1'b1);
      check("rst_sel", bif.dev_sel, 3'b000);
      check("rst_rv", bif.resp_valid, 1'b0);
      check("rst_hwint", hwint, 6'd0);
      rst = 1'b0;
      @(negedge clk);
      check("hwint_release", hwint, 6'b000011);
      last_irq = 2'b11;
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         if (bif.resp_valid) seen++;
         @(negedge clk);
      end
      check("rst_no_resp", 32'(seen), 32'd0);
   endtask

   initial begin
      logic [31:0] addr;
      logic [3:0]  be;
      int          d;
      bif.req_valid = 1'b0;
      bif.req_we    = 1'b0;
      bif.req_addr  = '0;
      bif.req_be    = '0;
      bif.req_wdata = '0;
      bif.dev_ack   = '0;
      bif.dev_rdata = '0;

      repeat (3) @(negedge clk);
      check("rst_ready0", bif.req_ready, 1'b1);
      check("rst_rv0", bif.resp_valid, 1'b0);
      check("rst_rdata0", bif.resp_rdata, 32'd0);
      check("rst_err0", bif.resp_err, 1'b0);
      check("rst_sel0", bif.dev_sel, 3'b000);
      check("rst_daddr0", bif.dev_addr, 32'd0);
      check("rst_dwdata0", bif.dev_wdata, 32'd0);
      check("rst_dbe0", bif.dev_be, 4'd0);
      check("rst_hwint0", hwint, 6'd0);

      dev_irq = 2'b10;
      @(negedge clk);
      check("hwint_in_rst", hwint, 6'd0);
      rst = 1'b0;
      @(negedge clk);
      check("hwint_irq1", hwint, 6'b000010);
      last_irq = 2'b10;

      run_txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h10, 4'hF, 32'h0, 0, {$urandom, $urandom, 32'hDEAD_BEEF});
      run_txn(1'b0, 32'h7F04, 4'hF, 32'h0, 3, {$urandom, 32'h5, $urandom});
      run_txn(1'b0, 32'h5000, 4'hF, 32'h0, 0, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h10, 4'h0, 32'h0, 0, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h7F10, 4'hF, 32'h0, NEVER, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h2FFF, 4'h8, 32'h0, 1, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h3000, 4'hF, 32'h0, 0, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h7F0B, 4'h8, 32'h0, 0, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h7F0C, 4'hF, 32'h0, 0, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h7F1B, 4'h8, 32'h0, 2, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h7F1C, 4'hF, 32'h0, 0, {$urandom, $urandom, $urandom});
      run_txn(1'b0, 32'h7F08, 4'h1, 32'h0, TIMEOUT - 1, {$urandom, $urandom, $urandom});

      reset_in_wait();

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0:       addr = $urandom_range(0, 32'h2FFF);
            1:       addr = T0_BASE + $urandom_range(0, 15);
            2:       addr = T1_BASE + $urandom_range(0, 15);
            3:       addr = $urandom;
            4:       addr = 32'h2FFC + $urandom_range(0, 7);
            default: addr = 32'h7EFC + $urandom_range(0, 39);
         endcase
         be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20))
                                          : int'($urandom_range(0, 5));
         run_txn(1'($urandom_range(0, 1)), addr, be, $urandom, d,
                 {$urandom, $urandom, $urandom});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bridge_responder.md
Name: bridge_responder

Overview:
CPU-facing responder end of the data-side bridge interface. Accepts one load/store request at a time from the MEM stage and decodes the address to data memory, TIMER0 or TIMER1. Runs the device handshake with wait-state and timeout support, then returns a single-cycle response.
Also registers device interrupt lines into the hardware-interrupt vector consumed by CP0.

Parameters:
DM_LIMIT, 32'h0000_2FFF, last byte address of data memory (DM spans 0..DM_LIMIT)
T0_BASE, 32'h0000_7F00, TIMER0 base; window is 12 bytes (base..base+0xB)
T1_BASE, 32'h0000_7F10, TIMER1 base; window is 12 bytes
TIMEOUT, 16, max WAIT cycles without ack before error response (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  responder can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_be  in  4  byte enables
req_wdata  in  32  store data
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  load data (0 for stores and errors)
resp_err  out  1  unmapped, be==0, or timeout
dev_sel  out  3  one-hot {T1,T0,DM}
dev_we  out  1  latched we
dev_addr  out  32  latched address, offset from window base
dev_be  out  4  latched be
dev_wdata  out  32  latched wdata
dev_ack  in  3  per-device completion
dev_rdata  in  96  {T1,T0,DM} read data, 32 each
dev_irq  in  2  {T1,T0} interrupt levels
hwint  out  6  registered {4'b0, irq1, irq0} to CP0

Behaviour:
- One clock domain. Synchronous active-high reset: state IDLE; all outputs 0 except req_ready=1; latched fields 0; hwint=0.
- FSM states:
  - IDLE: req_ready=1. Accept when req_valid&&req_ready at an edge; latch we/addr/be/wdata; decode.
    - Hit and be!=0: go to WAIT, drive one-hot dev_sel from the next cycle.
    - Miss or be==0: go to RESP with err=1, no dev_sel.
  - WAIT: dev_sel/dev_* held stable; counter increments each cycle starting from 0.
    - dev_ack[sel] sampled high: capture dev_rdata slice (0 if store), go to RESP.
    - Otherwise, when counter==TIMEOUT-1: set err=1, rdata=0, go to RESP.
    - dev_sel drops on leaving WAIT.
    - Acks from unselected devices are ignored.
  - RESP: resp_valid=1 for exactly one cycle with latched rdata/err, then IDLE. req_ready=0; req_valid here is not accepted.
- Latency (accept edge = k):
  - Zero-wait device: dev_sel high in cycle k+1; ack sampled at edge k+1; resp_valid in cycle k+2.
  - Each extra wait cycle adds 1.
  - Decode error: resp_valid in cycle k+1.
  - Back-to-back requests: next accept earliest at the edge ending the RESP cycle's following IDLE cycle, i.e. a 3-cycle minimum issue interval.
- Decode:
  - Ranges are inclusive: DM if addr<=DM_LIMIT; T0 if T0_BASE<=addr<=T0_BASE+11; T1 likewise.
  - Overlap priority: DM > T0 > T1.
  - addr[1:0] is ignored for decode; be carries the lane information.
- resp_rdata and resp_err are held at 0 outside RESP.
- hwint updates every cycle from dev_irq, independent of FSM state; 1-cycle delay.
- Reset asserted in any state: next cycle is IDLE, dev_sel=0, resp_valid=0; the in-flight transaction is dropped with no response.

Decomposition:
- bridge_pkg:
  - state enum {IDLE, WAIT, RESP}
  - device index enum {DEV_DM=0, DEV_T0=1, DEV_T1=2}
  - NDEV=3
  - timer window size 12
  - default address constants
- One combinational sub-module, bridge_addr_decode: addr -> one-hot hit[2:0] plus window offset. Instantiated once.

Test Plan:
- Store DM addr 0x10, be=4'hF, wdata=0xDEADBEEF, DM acks immediately -> dev_sel=3'b001 in k+1, resp_valid in k+2, err=0, rdata=0. Then load from 0x10 with ack and dev_rdata=0xDEADBEEF -> resp_rdata=0xDEADBEEF.
- Load 0x0000_7F04 with TIMER0 acking after 3 wait cycles, rdata 0x5 -> dev_addr=0x4, resp_valid in k+5, rdata=0x5.
- Load 0x0000_5000 (unmapped), or any mapped address with be=0 -> no dev_sel, resp_valid in k+1, err=1, rdata=0.
- TIMER1 never acks, TIMEOUT=16 -> dev_sel held for 16 cycles, then a single response with err=1; a spurious dev_ack[0] during WAIT is ignored.
- rst pulsed during WAIT -> next cycle req_ready=1, dev_sel=0, no resp_valid ever for the dropped request.
- dev_irq=2'b10 -> hwint=6'b000010 one cycle later; held low while rst=1.
